register_bank_param: RTL
========================

// Module: register_bank_param
// PURPOSE
//  Parametrised 2-read/1-write register file; generalises the CPU register bank in width, depth and forwarding.
//  Adds write-to-read bypass, optional hardwired-zero r0, a per-register pending-write scoreboard
//  and sticky out-of-range address detection. Sits between decode (reads/reserves) and writeback (writes).
// PARAMETERS
//  WIDTH      16   data width of each register
//  DEPTH      16   number of registers (2..2**ADDR_W)
//  ADDR_W     5    address port width; addresses >= DEPTH are out of range
//  MEM_OFFSET 512  reset value of r1 (memory offset register); truncated to WIDTH
//  ZERO_REG   0    1: r0 reads 0, writes/reserves to r0 ignored
//  BYPASS     1    1: same-cycle write forwards to read output; 0: read returns old value
// PORTS
//  clk               in  1       clock, all state updates on rising edge
//  reset             in  1       synchronous, active-low reset
//  read_1EN          in  1       port A read enable
//  read_1            in  ADDR_W  port A address
//  read_2EN          in  1       port B read enable
//  read_2            in  ADDR_W  port B address
//  writeEN           in  1       write enable
//  write_reg_address in  ADDR_W  write address
//  write_val         in  WIDTH   write data
//  reserveEN         in  1       mark reserve_addr pending (producer issued)
//  reserve_addr      in  ADDR_W  register to mark pending
//  clear_err         in  1       clears addr_err
//  line_a            out WIDTH   port A read data (registered)
//  line_b            out WIDTH   port B read data (registered)
//  busy_a            out 1       line_a data is stale (pending write, not forwarded)
//  busy_b            out 1       line_b data is stale
//  addr_err          out 1       sticky: an enabled access used an address >= DEPTH
// BEHAVIOUR
//  - Reset (reset==0 at posedge) overrides all other inputs: r1<=MEM_OFFSET, all other regs<=0,
//    line_a/line_b<=0, busy_a/busy_b<=0, all scoreboard bits<=0, addr_err<=0.
//  - Read: readEN high at edge N -> line/busy updated at edge N (visible cycle N+1); latency 1.
//    readEN low: line and busy hold previous values.
//  - Write: writeEN at edge N updates reg at edge N; visible to a read issued at edge N+1.
//  - Bypass (BYPASS=1): read addr == write addr, both enabled, addr valid, not zeroed r0
//    -> line <= write_val, busy <= 0. BYPASS=0 -> line <= old value, busy <= old pending bit.
//  - Both ports may read the same address; both receive identical data/busy.
//  - Scoreboard: reserveEN sets pending[reserve_addr]; writeEN clears pending[write_reg_address].
//    Reserve and write to same addr same edge -> pending stays 1 (new producer wins).
//  - busy_x <= pending[addr] (pre-edge value) AND NOT forwarded; a same-cycle reserve never affects busy_x.
//  - ZERO_REG=1: r0 always reads 0, busy 0; writes and reserves to r0 ignored; r0 never forwarded.
//  - Out of range (addr >= DEPTH): write/reserve ignored (no state change); read returns 0, busy 0.
//  - addr_err set on any enabled read/write/reserve with out-of-range addr; clear_err clears it;
//    set and clear same edge -> remains 1. Held until cleared or reset.
//  - reset low mid-operation: any same-edge write/reserve/read discarded.
// TESTING
//  1. Release reset, read r1/r0 on A/B -> next cycle line_a=512, line_b=0, busy 0, addr_err 0.
//  2. Write r5=16'hBEEF with read_1=5 same edge, BYPASS=1 -> line_a=16'hBEEF; BYPASS=0 -> line_a=0, then 16'hBEEF on reread.
//  3. reserve r7, read r7 -> busy_a=1; write r7=16'h0042 with reserve r7 same edge -> pending stays, next read busy_a=1;
//     write r7 alone -> following read line_a=16'h0042, busy_a=0.
//  4. ZERO_REG=1: write r0=16'hFFFF, reserve r0, read r0 -> line_a=0, busy_a=0.
//  5. DEPTH=16: write addr 20 -> no reg changes, addr_err=1; read addr 20 -> line_b=0; clear_err with new bad
//     access same edge -> addr_err stays 1; clear_err alone -> 0.
//  6. Assert reset during write r3=16'h1234 and reserve r3 -> r3 reads 0, busy 0, outputs 0 after release.

Source files
------------

// File: rtl/register_bank_param.sv
// Two-read/one-write register file with write bypass, optional zero r0,
// pending-write scoreboard and sticky out-of-range address flag.
module register_bank_param #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 5,
  parameter int MEM_OFFSET = 512,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_1EN,
  input  logic [ADDR_W-1:0] read_1,
  input  logic              read_2EN,
  input  logic [ADDR_W-1:0] read_2,
  input  logic              writeEN,
  input  logic [ADDR_W-1:0] write_reg_address,
  input  logic [WIDTH-1:0]  write_val,
  input  logic              reserveEN,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic              clear_err,
  output logic [WIDTH-1:0]  line_a,
  output logic [WIDTH-1:0]  line_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [WIDTH-1:0] r_line_a;
  logic [WIDTH-1:0] r_line_b;
  logic             r_busy_a;
  logic             r_busy_b;
  logic             r_err;

  logic w_va, w_vb, w_vw, w_vr;
  logic w_za, w_zb, w_zw, w_zr;
  logic w_wr_ok, w_rs_ok, w_err_set;
  logic [IDX_W-1:0] w_ia, w_ib, w_iw, w_ir;
  logic [WIDTH-1:0] w_line_a, w_line_b;
  logic             w_busy_a, w_busy_b;

  assign w_va = {1'b0, read_1} < LIM;
  assign w_vb = {1'b0, read_2} < LIM;
  assign w_vw = {1'b0, write_reg_address} < LIM;
  assign w_vr = {1'b0, reserve_addr} < LIM;

  assign w_za = (ZERO_REG != 0) && (read_1 == '0);
  assign w_zb = (ZERO_REG != 0) && (read_2 == '0);
  assign w_zw = (ZERO_REG != 0) && (write_reg_address == '0);
  assign w_zr = (ZERO_REG != 0) && (reserve_addr == '0);

  assign w_ia = read_1[IDX_W-1:0];
  assign w_ib = read_2[IDX_W-1:0];
  assign w_iw = write_reg_address[IDX_W-1:0];
  assign w_ir = reserve_addr[IDX_W-1:0];

  assign w_wr_ok = writeEN && w_vw && !w_zw;
  assign w_rs_ok = reserveEN && w_vr && !w_zr;

  assign w_err_set = (read_1EN && !w_va) || (read_2EN && !w_vb)
                  || (writeEN && !w_vw) || (reserveEN && !w_vr);

  // busy uses the pre-edge pending bit; a same-edge reserve is invisible
  always_comb begin
    w_line_a = '0;
    w_busy_a = 1'b0;
    if (w_va && !w_za) begin
      if ((BYPASS != 0) && w_wr_ok && (read_1 == write_reg_address)) begin
        w_line_a = write_val;
      end else begin
        w_line_a = r_regs[w_ia];
        w_busy_a = r_pend[w_ia];
      end
    end
  end

  always_comb begin
    w_line_b = '0;
    w_busy_b = 1'b0;
    if (w_vb && !w_zb) begin
      if ((BYPASS != 0) && w_wr_ok && (read_2 == write_reg_address)) begin
        w_line_b = write_val;
      end else begin
        w_line_b = r_regs[w_ib];
        w_busy_b = r_pend[w_ib];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= (i == 1) ? WIDTH'(MEM_OFFSET) : '0;
      end
      r_pend   <= '0;
      r_line_a <= '0;
      r_line_b <= '0;
      r_busy_a <= 1'b0;
      r_busy_b <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_regs[w_iw] <= write_val;
      end
      // a reserve beats a write to the same register: new producer wins
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rs_ok && (w_ir == IDX_W'(i))) begin
          r_pend[i] <= 1'b1;
        end else if (w_wr_ok && (w_iw == IDX_W'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (read_1EN) begin
        r_line_a <= w_line_a;
        r_busy_a <= w_busy_a;
      end
      if (read_2EN) begin
        r_line_b <= w_line_b;
        r_busy_b <= w_busy_b;
      end
      r_err <= w_err_set | (r_err & ~clear_err);
    end
  end

  assign line_a   = r_line_a;
  assign line_b   = r_line_b;
  assign busy_a   = r_busy_a;
  assign busy_b   = r_busy_b;
  assign addr_err = r_err;

endmodule
